// File: rtl/enc_pkg.sv
// Shared types and parameter bounds for the multi-channel encoder counter.
package enc_pkg;

  // Measurement FSM states
  typedef enum logic [1:0] {
    ENC_IDLE   = 2'd0,
    ENC_WAIT_Z = 2'd1,
    ENC_COUNT  = 2'd2,
    ENC_DONE   = 2'd3
  } enc_state_e;

  // Legal parameter ranges
  localparam int N_CH_MIN        = 1;
  localparam int N_CH_MAX        = 16;
  localparam int CNT_W_MIN       = 8;
  localparam int CNT_W_MAX       = 64;
  localparam int N_Z_MIN         = 1;
  localparam int N_Z_MAX         = 8;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

endpackage

// File: rtl/enc_sync_edge.sv
// Multi-bit pin synchroniser followed by a one-flop edge detector.
// lvl, rise and fall are all registered and mutually aligned: in the cycle
// rise is high, lvl is already high (and likewise fall with lvl low).
module enc_sync_edge #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] lvl,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [DEPTH-1:0][W-1:0] sync_r;
  logic [W-1:0]            lvl_r;
  logic [W-1:0]            rise_r;
  logic [W-1:0]            fall_r;

  // Synchroniser chain, then delayed level and edge flags from the last stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {(DEPTH*W){1'b0}};
      lvl_r  <= {W{1'b0}};
      rise_r <= {W{1'b0}};
      fall_r <= {W{1'b0}};
    end else begin
      sync_r <= {sync_r[DEPTH-2:0], din};
      lvl_r  <= sync_r[DEPTH-1];
      rise_r <= sync_r[DEPTH-1] & ~lvl_r;
      fall_r <= ~sync_r[DEPTH-1] & lvl_r;
    end
  end

  assign lvl  = lvl_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/enc_multi_cnt.sv
// Multi-channel encoder pulse counter: counts A-phase edges per channel in a
// window opened and closed by rising edges of a run-time selected Z input.
module enc_multi_cnt
  import enc_pkg::*;
#(
  parameter  int N_CH        = 2,
  parameter  int CNT_W       = 64,
  parameter  int N_Z         = 2,
  parameter  int SYNC_STAGES = 2,
  localparam int ZSEL_W      = (N_Z > 1) ? $clog2(N_Z) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  I_ARM,
  input  logic                  I_EDGE_MODE,
  input  logic [ZSEL_W-1:0]     I_ZSEL,
  input  logic [N_CH-1:0]       I_A,
  input  logic [N_Z-1:0]        I_Z,
  output logic [N_CH*CNT_W-1:0] O_CNT,
  output logic [N_CH-1:0]       O_OVERFLOW,
  output logic [N_CH-1:0]       O_READY,
  output logic                  O_BUSY
);

  localparam logic [ZSEL_W:0]  N_Z_L   = N_Z[ZSEL_W:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Synchronised pins; names containing "unused" mark detector outputs this
  // block has no use for
  logic [N_CH-1:0] a_rise_s;
  logic [N_CH-1:0] a_fall_s;
  logic [N_CH-1:0] a_lvl_unused_s;
  logic [N_Z-1:0]  z_rise_s;
  logic [N_Z-1:0]  z_fall_unused_s;
  logic [N_Z-1:0]  z_lvl_unused_s;
  logic            arm_rise_s;
  logic            arm_lvl_s;
  logic            arm_fall_unused_s;

  enc_sync_edge #(.W(N_CH), .DEPTH(SYNC_STAGES)) u_sync_a (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (I_A),
    .lvl   (a_lvl_unused_s),
    .rise  (a_rise_s),
    .fall  (a_fall_s)
  );

  enc_sync_edge #(.W(N_Z), .DEPTH(SYNC_STAGES)) u_sync_z (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (I_Z),
    .lvl   (z_lvl_unused_s),
    .rise  (z_rise_s),
    .fall  (z_fall_unused_s)
  );

  enc_sync_edge #(.W(1), .DEPTH(SYNC_STAGES)) u_sync_arm (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (I_ARM),
    .lvl   (arm_lvl_s),
    .rise  (arm_rise_s),
    .fall  (arm_fall_unused_s)
  );

  enc_state_e        state_r;
  enc_state_e        state_nxt_s;
  logic              mode_r;
  logic [ZSEL_W-1:0] zsel_r;
  logic [ZSEL_W-1:0] zsel_eff_s;
  logic              zsel_rise_s;
  logic              start_s;
  logic              close_s;
  logic              count_en_s;
  logic              ready_r;
  logic              busy_r;

  // Out-of-range index selections fall back to Z[0]
  always_comb begin
    if ({1'b0, I_ZSEL} < N_Z_L) begin
      zsel_eff_s = I_ZSEL;
    end else begin
      zsel_eff_s = {ZSEL_W{1'b0}};
    end
  end

  assign zsel_rise_s = z_rise_s[zsel_r];
  assign count_en_s  = (state_r == ENC_COUNT) && arm_lvl_s;

  // Next-state logic with start/close strobes for the datapath
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    close_s     = 1'b0;
    case (state_r)
      ENC_IDLE: begin
        if (arm_rise_s) begin
          state_nxt_s = ENC_WAIT_Z;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = ENC_IDLE;
        end
      end
      ENC_WAIT_Z: begin
        if (!arm_lvl_s) begin
          state_nxt_s = ENC_IDLE;
        end else if (zsel_rise_s) begin
          state_nxt_s = ENC_COUNT;
        end else begin
          state_nxt_s = ENC_WAIT_Z;
        end
      end
      ENC_COUNT: begin
        if (!arm_lvl_s) begin
          state_nxt_s = ENC_IDLE;
        end else if (zsel_rise_s) begin
          state_nxt_s = ENC_DONE;
          close_s     = 1'b1;
        end else begin
          state_nxt_s = ENC_COUNT;
        end
      end
      ENC_DONE: begin
        if (arm_rise_s) begin
          state_nxt_s = ENC_WAIT_Z;
          start_s     = 1'b1;
        end else if (!arm_lvl_s) begin
          state_nxt_s = ENC_IDLE;
        end else begin
          state_nxt_s = ENC_DONE;
        end
      end
      default: begin
        state_nxt_s = ENC_IDLE;
      end
    endcase
  end

  // FSM state, captured configuration and shared ready/busy flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ENC_IDLE;
      mode_r  <= 1'b0;
      zsel_r  <= {ZSEL_W{1'b0}};
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ENC_WAIT_Z) || (state_nxt_s == ENC_COUNT);
      if (start_s) begin
        mode_r  <= I_EDGE_MODE;
        zsel_r  <= zsel_eff_s;
        ready_r <= 1'b0;
      end else if (close_s) begin
        ready_r <= 1'b1;
      end
    end
  end

  assign O_READY = {N_CH{ready_r}};
  assign O_BUSY  = busy_r;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_W-1:0] live_r;
    logic [CNT_W-1:0] live_nxt_s;
    logic [CNT_W-1:0] cnt_out_r;
    logic             ovf_r;
    logic             edge_s;
    logic             hit_s;
    logic             at_max_s;

    // Qualifying edge for this channel under the captured mode
    always_comb begin
      if (mode_r) begin
        edge_s = a_rise_s[k] | a_fall_s[k];
      end else begin
        edge_s = a_rise_s[k];
      end
    end

    assign hit_s    = count_en_s & edge_s;
    assign at_max_s = (live_r == CNT_MAX);

    // Saturating increment; an edge in the closing cycle is included
    always_comb begin
      if (hit_s && !at_max_s) begin
        live_nxt_s = live_r + CNT_ONE;
      end else begin
        live_nxt_s = live_r;
      end
    end

    // Live counter, sticky overflow and latched result for this channel
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        live_r    <= {CNT_W{1'b0}};
        cnt_out_r <= {CNT_W{1'b0}};
        ovf_r     <= 1'b0;
      end else if (start_s) begin
        live_r <= {CNT_W{1'b0}};
        ovf_r  <= 1'b0;
      end else begin
        live_r <= live_nxt_s;
        if (hit_s && at_max_s) begin
          ovf_r <= 1'b1;
        end
        if (close_s) begin
          cnt_out_r <= live_nxt_s;
        end
      end
    end

    assign O_CNT[k*CNT_W +: CNT_W] = cnt_out_r;
    assign O_OVERFLOW[k]           = ovf_r;
  end

endmodule

// File: tb/tb_enc_multi_cnt.sv
// Self-checking bench for enc_multi_cnt: pin-level pulse trains with a
// counting model of the measurement window.
module tb_enc_multi_cnt;

  localparam int N_CH  = 2;
  localparam int CNT_W = 8;
  localparam int N_Z   = 2;
  localparam int SS    = 2;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic                  CLK = 1'b0;
  logic                  RST_N = 1'b0;
  logic                  I_ARM = 1'b0;
  logic                  I_EDGE_MODE = 1'b0;
  logic [0:0]            I_ZSEL = 1'b0;
  logic [N_CH-1:0]       I_A = '0;
  logic [N_Z-1:0]        I_Z = '0;
  logic [N_CH*CNT_W-1:0] O_CNT;
  logic [N_CH-1:0]       O_OVERFLOW;
  logic [N_CH-1:0]       O_READY;
  logic                  O_BUSY;

  int n_cmp = 0;
  int n_mis = 0;

  enc_multi_cnt #(.N_CH(N_CH), .CNT_W(CNT_W), .N_Z(N_Z), .SYNC_STAGES(SS)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .I_ARM       (I_ARM),
    .I_EDGE_MODE (I_EDGE_MODE),
    .I_ZSEL      (I_ZSEL),
    .I_A         (I_A),
    .I_Z         (I_Z),
    .O_CNT       (O_CNT),
    .O_OVERFLOW  (O_OVERFLOW),
    .O_READY     (O_READY),
    .O_BUSY      (O_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Model: edges seen in the window, saturated at the counter maximum
  function automatic int model_cnt(input int n, input bit mode);
    int e;
    e = mode ? 2 * n : n;
    return (e > MAXC) ? MAXC : e;
  endfunction

  function automatic bit model_ovf(input int n, input bit mode);
    int e;
    e = mode ? 2 * n : n;
    return e > MAXC;
  endfunction

  task automatic pulse_z(input int idx);
    I_Z[idx] = 1'b1;
    cyc(2);
    I_Z[idx] = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_a(input int n0, input int n1);
    int m;
    m = (n0 > n1) ? n0 : n1;
    for (int i = 0; i < m; i++) begin
      I_A[0] = (i < n0);
      I_A[1] = (i < n1);
      cyc(2 + $urandom_range(0, 1));
      I_A = '0;
      cyc(2 + $urandom_range(0, 1));
    end
  endtask

  // Arm with the given config, then scramble config inputs (must be ignored)
  task automatic arm_start(input bit mode, input bit zsel);
    I_ARM = 1'b0;
    cyc(SS + 3);
    I_EDGE_MODE = mode;
    I_ZSEL      = zsel;
    I_ARM       = 1'b1;
    cyc(SS + 3);
    check("busy_armed", 64'(O_BUSY), 64'd1);
    check("ready_cleared", 64'(O_READY), 64'd0);
    I_EDGE_MODE = 1'($urandom_range(0, 1));
    I_ZSEL      = 1'($urandom_range(0, 1));
  endtask

  task automatic finish_check(input string tag, input bit mode, input int n0, input int n1);
    cyc(SS + 3);
    check({tag, "_cnt0"}, 64'(O_CNT[0 +: CNT_W]), 64'(model_cnt(n0, mode)));
    check({tag, "_cnt1"}, 64'(O_CNT[CNT_W +: CNT_W]), 64'(model_cnt(n1, mode)));
    check({tag, "_ovf"}, 64'(O_OVERFLOW), 64'({model_ovf(n1, mode), model_ovf(n0, mode)}));
    check({tag, "_ready"}, 64'(O_READY), 64'd3);
    check({tag, "_busy"}, 64'(O_BUSY), 64'd0);
  endtask

  task automatic run_meas(input string tag, input bit mode, input bit zsel,
                          input int n0, input int n1, input bit other_z);
    arm_start(mode, zsel);
    pulse_z(int'(zsel));
    if (other_z) begin
      pulse_z(int'(!zsel));
    end
    pulse_a(n0, n1);
    if (other_z) begin
      pulse_z(int'(!zsel));
    end
    pulse_z(int'(zsel));
    finish_check(tag, mode, n0, n1);
  endtask

  initial begin
    RST_N = 1'b0;
    cyc(3);
    check("rst_cnt", 64'(O_CNT), 64'd0);
    check("rst_ovf", 64'(O_OVERFLOW), 64'd0);
    check("rst_ready", 64'(O_READY), 64'd0);
    check("rst_busy", 64'(O_BUSY), 64'd0);
    RST_N = 1'b1;
    cyc(2);

    // Directed cases from the plan
    run_meas("basic", 1'b0, 1'b1, 100, 37, 1'b0);
    run_meas("both_edges", 1'b1, 1'b0, 10, 0, 1'b1);
    run_meas("ovf", 1'b0, 1'b1, 300, 10, 1'b0);
    arm_start(1'b0, 1'b0);
    check("ovf_cleared_on_arm", 64'(O_OVERFLOW), 64'd0);

    // Randomised windows
    for (int it = 0; it < 6; it++) begin
      bit m;
      bit zs;
      m  = 1'($urandom_range(0, 1));
      zs = 1'($urandom_range(0, 1));
      run_meas("rand", m, zs, int'($urandom_range(0, 120)), int'($urandom_range(0, 120)),
               1'($urandom_range(0, 1)));
    end

    // A edge coincident with closing Z: included
    arm_start(1'b0, 1'b1);
    pulse_z(1);
    pulse_a(3, 1);
    I_A[0] = 1'b1;
    I_Z[1] = 1'b1;
    cyc(2);
    I_A = '0;
    I_Z = '0;
    cyc(SS + 3);
    check("coinc_close", 64'(O_CNT[0 +: CNT_W]), 64'd4);
    check("coinc_close_ch1", 64'(O_CNT[CNT_W +: CNT_W]), 64'd1);

    // A edge coincident with opening Z: excluded
    arm_start(1'b0, 1'b0);
    I_A[0] = 1'b1;
    I_Z[0] = 1'b1;
    cyc(2);
    I_A = '0;
    I_Z = '0;
    cyc(2);
    pulse_a(3, 2);
    pulse_z(0);
    finish_check("coinc_open", 1'b0, 3, 2);

    // Result 42, arm low in DONE keeps it, then abort mid-COUNT
    run_meas("pre_abort", 1'b0, 1'b0, 42, 7, 1'b0);
    I_ARM = 1'b0;
    cyc(SS + 3);
    check("done_disarm_ready", 64'(O_READY), 64'd3);
    check("done_disarm_cnt", 64'(O_CNT[0 +: CNT_W]), 64'd42);
    arm_start(1'b0, 1'b0);
    pulse_z(0);
    pulse_a(5, 5);
    I_ARM = 1'b0;
    cyc(SS + 3);
    check("abort_busy", 64'(O_BUSY), 64'd0);
    check("abort_ready", 64'(O_READY), 64'd0);
    check("abort_cnt", 64'(O_CNT[0 +: CNT_W]), 64'd42);
    pulse_z(0);
    cyc(SS + 3);
    check("abort_z_ignored", 64'(O_CNT[0 +: CNT_W]), 64'd42);
    check("abort_z_ready", 64'(O_READY), 64'd0);

    // Asynchronous reset during COUNT
    arm_start(1'b0, 1'b1);
    pulse_z(1);
    pulse_a(4, 4);
    #2;
    RST_N = 1'b0;
    I_ARM = 1'b0;
    #1;
    check("async_rst_cnt", 64'(O_CNT), 64'd0);
    check("async_rst_busy", 64'(O_BUSY), 64'd0);
    check("async_rst_ready", 64'(O_READY), 64'd0);
    check("async_rst_ovf", 64'(O_OVERFLOW), 64'd0);
    cyc(3);
    RST_N = 1'b1;
    cyc(2);
    run_meas("post_rst", 1'b0, 1'b1, 5, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/enc_multi_cnt.md
# enc_multi_cnt

Parametrised multi-channel encoder pulse counter; successor to the fixed two-channel encoder counter top level. Counts A-phase edges on `N_CH` channels inside a window bounded by two index (Z) pulses. The Z source is chosen at run time from `N_Z` index inputs. Provides per-channel saturating counts, sticky overflow, a done/ready flag and a selectable edge mode, and feeds the DAQ readout registers.

## Interface
Parameters:
- `N_CH`, 2: number of A-phase counting channels (1..16).
- `CNT_W`, 64: counter width per channel (8..64).
- `N_Z`, 2: number of index inputs (1..8).
- `SYNC_STAGES`, 2: synchroniser depth on every pin input (2..4).

Ports:
- `CLK`, in, 1: sole clock.
- `RST_N`, in, 1: reset, asynchronous assert, active-low.
- `I_ARM`, in, 1: level; a rising edge starts a measurement, low aborts it.
- `I_EDGE_MODE`, in, 1: 0 counts A rising edges only, 1 counts both edges. Sampled on the arm edge.
- `I_ZSEL`, in, max(1,$clog2(N_Z)): index source select. Sampled on the arm edge. Out-of-range values select Z[0].
- `I_A`, in, N_CH: asynchronous A-phase pins.
- `I_Z`, in, N_Z: asynchronous index pins.
- `O_CNT`, out, N_CH*CNT_W: latched counts. Channel k occupies bits [k*CNT_W +: CNT_W].
- `O_OVERFLOW`, out, N_CH: per-channel sticky saturation flag.
- `O_READY`, out, N_CH: per-channel result valid.
- `O_BUSY`, out, 1: high while the shared FSM is in WAIT_Z or COUNT.

## Operation
- All of `I_A`, `I_Z` and `I_ARM` pass through `SYNC_STAGES` flops and a 1-flop edge detector.
- One shared FSM (IDLE, WAIT_Z, COUNT, DONE) with per-channel counters.
- IDLE:
  - Arm rising edge: go to WAIT_Z.
  - In the same cycle: clear all live counters, clear `O_OVERFLOW` and `O_READY`, latch the mode and Z select.
- WAIT_Z:
  - Rising edge on the selected Z: go to COUNT.
  - A edges in this state and in the Z-detect cycle are not counted.
- COUNT:
  - Each qualifying A edge adds 1 to that channel's live counter.
  - At all-ones the counter holds and sets `O_OVERFLOW[k]`.
  - Next rising edge on the selected Z: go to DONE, copy live counters to `O_CNT`, set all `O_READY` bits.
  - An A edge in the same cycle as the closing Z edge is counted, i.e. included in the latched value.
- DONE: hold outputs. A new arm rising edge behaves as in IDLE.
- `I_ARM` synchronised low in WAIT_Z or COUNT: go to IDLE. `O_CNT` keeps the previous result, `O_READY` stays 0, live counters are discarded.
- `I_ARM` low in DONE: go to IDLE and keep the result and `O_READY`.
- Changes to `I_ZSEL` or `I_EDGE_MODE` mid-measurement have no effect.
- Counter arithmetic is unsigned `CNT_W`-bit, saturating, never wrapping.

## Timing
- Reset values: `O_CNT` = 0, `O_OVERFLOW` = 0, `O_READY` = 0, `O_BUSY` = 0, FSM in IDLE, synchronisers at 0.
- Reset mid-measurement returns everything to reset values immediately (asynchronous).
- Pin-to-detect latency is `SYNC_STAGES`+1 CLK cycles for A, Z and ARM alike.
- `O_CNT` and `O_READY` update 1 cycle after the closing Z is detected, i.e. `SYNC_STAGES`+2 cycles after the pin edge.
- `O_BUSY` rises 1 cycle after arm detect and falls together with the `O_READY` rise.
- Input pulses must be at least 2 CLK periods high and 2 low. Shorter pulses may be lost. This is not checked.
- Throughput is one counted edge per channel per cycle.

## Structure
- Shared package `enc_pkg`: FSM state enum (`ENC_IDLE`, `ENC_WAIT_Z`, `ENC_COUNT`, `ENC_DONE`) and the parameter bounds as constants.
- Sub-module `enc_sync_edge` (parametrised width and depth): synchroniser plus rising/falling edge detect. Instantiated once each for the A, Z and ARM buses.
- The per-channel counter is a generate loop inside `enc_multi_cnt`, not a separate module.

## Test plan
- N_CH=2, CNT_W=16, mode 0, ZSEL=1:
  - Arm, Z1 pulse, 100 A0 and 37 A1 pulses, Z1 pulse.
  - Expect `O_CNT` ch0 = 100, ch1 = 37, `O_READY` = 2'b11, `O_OVERFLOW` = 0.
- Mode 1, ZSEL=0, 10 full A0 periods between Z0 pulses → ch0 = 20. Pulses on Z1 are ignored.
- CNT_W=8, 300 A0 pulses in window → ch0 = 255, `O_OVERFLOW[0]` = 1. A new arm clears the flag.
- An A0 edge coincident with the closing Z edge (both at the synchroniser output) → it is included. One coincident with the opening Z edge → it is excluded.
- `I_ARM` dropped mid-COUNT after a previous result of 42 → FSM returns to IDLE, `O_CNT` stays 42, `O_READY` = 0.
- `RST_N` asserted during COUNT → all outputs 0 asynchronously. After release, a full measurement of 5 pulses yields 5.
